// File: rtl/mmc_pkg.sv
// Shared types and constants for the MMC game core: FSM states, winner encoding
// and count direction values.
package mmc_pkg;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_t;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/mmc_step_counter.sv
// Step counter for the MMC game: init load plus up/down stepping, wrapping by
// default or saturating at the rails when MMC_SAT_EN is defined.
module mmc_step_counter
  import mmc_pkg::*;
#(
  parameter int CNT_W  = 3,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              init,
  input  logic [CNT_W-1:0]  init_val,
  output logic [CNT_W-1:0]  count,
  output logic              hit_max,
  output logic              hit_min
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_nxt;
  logic             step_upd;

`ifdef MMC_SAT_EN
  // One extra bit of headroom so an upward overshoot is visible before clamping.
  localparam int WW = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 1;

  logic [WW-1:0] up_sum;
  logic          dn_under;

  assign up_sum   = WW'(count_reg) + WW'(step);
  assign dn_under = WW'(step) > WW'(count_reg);

  always_comb begin
    count_nxt = count_reg;
    if (dir == DIR_UP) begin
      if (up_sum > WW'(CNT_MAX)) count_nxt = CNT_MAX;
      else                       count_nxt = up_sum[CNT_W-1:0];
    end else begin
      if (dn_under) count_nxt = CNT_ZERO;
      else          count_nxt = count_reg - CNT_W'(step);
    end
  end
`else
  always_comb begin
    count_nxt = count_reg;
    if (dir == DIR_UP) count_nxt = count_reg + CNT_W'(step);
    else               count_nxt = count_reg - CNT_W'(step);
  end
`endif

  // Only a real step that moves the count can score; loads and holds never do.
  assign step_upd = en && !init && (step != '0) && (count_nxt != count_reg);
  assign hit_max  = step_upd && (count_nxt == CNT_MAX);
  assign hit_min  = step_upd && (count_nxt == CNT_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      if (init)              count_reg <= init_val;
      else if (step != '0)   count_reg <= count_nxt;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mmc_game_gen.sv
// MMC game core top: PLAY/OVER FSM, score registers, win pulses and ack handshake.
// Optional MMC_SAT_EN makes the counter saturate instead of wrap.
module mmc_game_gen
  import mmc_pkg::*;
#(
  parameter int CNT_W     = 3,
  parameter int STEP_W    = 2,
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dir,
  input  logic [STEP_W-1:0]  step,
  input  logic               init,
  input  logic [CNT_W-1:0]   init_val,
  input  logic               ack,
  output logic [CNT_W-1:0]   count,
  output logic               winner,
  output logic               loser,
  output logic [SCORE_W-1:0] winner_score,
  output logic [SCORE_W-1:0] loser_score,
  output logic               gameover,
  output logic [1:0]         who
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_t             state_reg, state_next;
  who_t               who_reg, who_next;
  logic [SCORE_W-1:0] win_score_reg, win_score_next;
  logic [SCORE_W-1:0] lose_score_reg, lose_score_next;
  logic               winner_reg, winner_next;
  logic               loser_reg, loser_next;
  logic               cnt_en;
  logic               cnt_clr;
  logic               hit_max;
  logic               hit_min;

  // Kept outside the FSM process so the counter's hit flags never loop back.
  assign cnt_en  = (state_reg == PLAY);
  assign cnt_clr = (state_reg == OVER) && ack;

  mmc_step_counter #(
    .CNT_W  (CNT_W),
    .STEP_W (STEP_W)
  ) u_step_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .dir      (dir),
    .step     (step),
    .init     (init),
    .init_val (init_val),
    .count    (count),
    .hit_max  (hit_max),
    .hit_min  (hit_min)
  );

  always_comb begin
    state_next      = state_reg;
    who_next        = who_reg;
    win_score_next  = win_score_reg;
    lose_score_next = lose_score_reg;
    winner_next     = 1'b0;
    loser_next      = 1'b0;
    case (state_reg)
      PLAY: begin
        if (hit_max) begin
          winner_next    = 1'b1;
          win_score_next = win_score_reg + SCORE_W'(1);
          if (win_score_next == WIN_VAL) begin
            who_next   = WHO_WINNER;
            state_next = OVER;
          end
        end else if (hit_min) begin
          loser_next      = 1'b1;
          lose_score_next = lose_score_reg + SCORE_W'(1);
          if (lose_score_next == WIN_VAL) begin
            who_next   = WHO_LOSER;
            state_next = OVER;
          end
        end
      end
      OVER: begin
        if (ack) begin
          win_score_next  = '0;
          lose_score_next = '0;
          who_next        = WHO_NONE;
          state_next      = PLAY;
        end
      end
      default: state_next = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= PLAY;
      who_reg        <= WHO_NONE;
      win_score_reg  <= '0;
      lose_score_reg <= '0;
      winner_reg     <= 1'b0;
      loser_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      who_reg        <= who_next;
      win_score_reg  <= win_score_next;
      lose_score_reg <= lose_score_next;
      winner_reg     <= winner_next;
      loser_reg      <= loser_next;
    end
  end

  assign winner       = winner_reg;
  assign loser        = loser_reg;
  assign winner_score = win_score_reg;
  assign loser_score  = lose_score_reg;
  assign gameover     = (state_reg == OVER);
  assign who          = who_reg;

endmodule

// File: tb/tb_mmc_game_gen.sv
// Scoreboard bench for mmc_game_gen: a behavioural model pushes expected outputs
// per driven cycle; they are popped and compared one cycle later.
module tb_mmc_game_gen;

  localparam int CNT_W   = 3;
  localparam int STEP_W  = 2;
  localparam int SCORE_W = 4;
  localparam int WIN     = 5;
  localparam int MAXV    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               dir;
  logic [STEP_W-1:0]  step;
  logic               init;
  logic [CNT_W-1:0]   init_val;
  logic               ack;
  logic [CNT_W-1:0]   count;
  logic               winner;
  logic               loser;
  logic [SCORE_W-1:0] winner_score;
  logic [SCORE_W-1:0] loser_score;
  logic               gameover;
  logic [1:0]         who;

  typedef struct {
    int count;
    int winner;
    int loser;
    int ws;
    int ls;
    int go;
    int who;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  int m_cnt, m_ws, m_ls, m_over, m_who;

  mmc_game_gen #(
    .CNT_W     (CNT_W),
    .STEP_W    (STEP_W),
    .SCORE_W   (SCORE_W),
    .WIN_SCORE (WIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dir          (dir),
    .step         (step),
    .init         (init),
    .init_val     (init_val),
    .ack          (ack),
    .count        (count),
    .winner       (winner),
    .loser        (loser),
    .winner_score (winner_score),
    .loser_score  (loser_score),
    .gameover     (gameover),
    .who          (who)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ws = 0; m_ls = 0; m_over = 0; m_who = 0;
  endtask

  // One clock: drive inputs, predict, push, wait an edge, pop and compare.
  task automatic drive(input string tag, input int d, input int s, input int i,
                       input int iv, input int a);
    exp_t e;
    exp_t got_e;
    int nxt;
    dir      = d[0];
    step     = s[STEP_W-1:0];
    init     = i[0];
    init_val = iv[CNT_W-1:0];
    ack      = a[0];
    e.winner = 0;
    e.loser  = 0;
    if (m_over != 0) begin
      if (a != 0) begin
        m_cnt = 0; m_ws = 0; m_ls = 0; m_who = 0; m_over = 0;
      end
    end else if (i != 0) begin
      m_cnt = iv;
    end else if (s != 0) begin
`ifdef MMC_SAT_EN
      if (d == 0) nxt = (m_cnt + s > MAXV) ? MAXV : m_cnt + s;
      else        nxt = (m_cnt - s < 0) ? 0 : m_cnt - s;
`else
      if (d == 0) nxt = (m_cnt + s) % (MAXV + 1);
      else        nxt = (m_cnt - s + MAXV + 1) % (MAXV + 1);
`endif
      if (nxt != m_cnt) begin
        if (nxt == MAXV) begin
          e.winner = 1; m_ws++;
          if (m_ws == WIN) begin m_over = 1; m_who = 2; end
        end else if (nxt == 0) begin
          e.loser = 1; m_ls++;
          if (m_ls == WIN) begin m_over = 1; m_who = 1; end
        end
      end
      m_cnt = nxt;
    end
    e.count = m_cnt; e.ws = m_ws; e.ls = m_ls; e.go = m_over; e.who = m_who;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    $display("%s: dir=%0d step=%0d init=%0d iv=%0d ack=%0d -> count=%0d w=%0d l=%0d ws=%0d ls=%0d go=%0d who=%0d",
             tag, d, s, i, iv, a, count, winner, loser, winner_score, loser_score, gameover, who);
    check_val({tag, ".count"}, int'(count), got_e.count);
    check_val({tag, ".winner"}, int'(winner), got_e.winner);
    check_val({tag, ".loser"}, int'(loser), got_e.loser);
    check_val({tag, ".winner_score"}, int'(winner_score), got_e.ws);
    check_val({tag, ".loser_score"}, int'(loser_score), got_e.ls);
    check_val({tag, ".gameover"}, int'(gameover), got_e.go);
    check_val({tag, ".who"}, int'(who), got_e.who);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".count"}, int'(count), 0);
    check_val({tag, ".winner"}, int'(winner), 0);
    check_val({tag, ".loser"}, int'(loser), 0);
    check_val({tag, ".winner_score"}, int'(winner_score), 0);
    check_val({tag, ".loser_score"}, int'(loser_score), 0);
    check_val({tag, ".gameover"}, int'(gameover), 0);
    check_val({tag, ".who"}, int'(who), 0);
  endtask

  initial begin
    rst_n = 1'b0; dir = 1'b0; step = '0; init = 1'b0; init_val = '0; ack = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;

    drive("wrap_init", 0, 0, 1, 5, 0);
    for (int k = 0; k < 3; k++) drive("wrap_up", 0, 2, 0, 0, 0);

    drive("hold_init", 0, 0, 1, 6, 0);
    drive("hold_step", 0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) drive("hold", 0, 0, 0, 0, 0);

    drive("init_prio", 0, 3, 1, 0, 0);

    for (int k = 0; k < 2; k++) begin
      drive("ws_init", 0, 0, 1, 6, 0);
      drive("ws_step", 0, 1, 0, 0, 0);
    end

    drive("sat_init", 0, 0, 1, 6, 0);
    drive("sat_up", 0, 3, 0, 0, 0);
    drive("sat_up2", 0, 3, 0, 0, 0);

    // Asynchronous reset between edges must clear outputs without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    #3;
    rst_n = 1'b1;

    drive("end_init", 0, 0, 1, 1, 0);
    for (int k = 0; k < 40 && m_over == 0; k++) drive("down", 1, 1, 0, 0, 0);
    check_val("game_over_reached", m_over, 1);
    for (int k = 0; k < 5; k++) drive("ignored", 0, 3, k & 1, 4, 0);
    drive("ack", 0, 0, 0, 0, 1);
    drive("ack_held", 0, 2, 0, 0, 1);
    drive("after_ack", 1, 1, 0, 0, 0);

    for (int k = 0; k < 60; k++)
      drive("rand", $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 7),
            ($urandom_range(0, 4) == 0) ? 1 : 0);

    check_val("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmc_game_gen.md
# mmc_game_gen

Parametrised multi-mode counter game and the next generation of the MMC game core. A counter of configurable width steps up or down by a programmable amount each cycle. Entering the maximum value scores a round for the winner; entering zero scores a round for the loser. The first side to reach a parametrised score ends the game, which then holds until the consumer acknowledges it. The block sits between the player control logic and the scoreboard/display logic.

## Interface
Parameters:
- CNT_W, 3: counter width. Count range is 0 .. 2^CNT_W-1.
- STEP_W, 2: step input width. Step values are 0 .. 2^STEP_W-1; step 0 means hold.
- SCORE_W, 4: width of each score register.
- WIN_SCORE, 15: score that ends the game. Legal range is 1 .. 2^SCORE_W-1.

Ports:
- clk  in  1  single clock; every register samples on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dir  in  1  count direction: 0 = up, 1 = down.
- step  in  STEP_W  step magnitude; 0 holds the count.
- init  in  1  load init_val into the count.
- init_val  in  CNT_W  value to load.
- ack  in  1  acknowledges game over and starts a new game.
- count  out  CNT_W  current counter value.
- winner  out  1  one-cycle pulse: count has just entered max.
- loser  out  1  one-cycle pulse: count has just entered 0.
- winner_score  out  SCORE_W  winner's running score.
- loser_score  out  SCORE_W  loser's running score.
- gameover  out  1  level; set while the FSM is in OVER.
- who  out  2  00 none, 01 LOSER_WON, 10 WINNER_WON.

## Operation
- FSM has two states, PLAY and OVER. Reset enters PLAY.
- PLAY, update priority per cycle:
  - init=1: count <= init_val. A load never scores.
  - otherwise step≠0: count <= count ± step, computed modulo 2^CNT_W (natural wrap for any step).
  - otherwise: count holds.
- Scoring happens only on a step update where count_nxt ≠ count:
  - count_nxt = max: winner pulses and winner_score increments.
  - count_nxt = 0: loser pulses and loser_score increments.
  - winner and loser are mutually exclusive by construction.
  - Sitting on a boundary while holding does not score again.
- Game end: if an increment makes a score equal WIN_SCORE, then on the same edge gameover <= 1, who is set, and the FSM goes to OVER.
- OVER:
  - count, scores and who are frozen.
  - dir, step and init are ignored. winner and loser stay 0.
- ack in OVER: count <= 0, both scores <= 0, who <= 00, gameover <= 0, FSM goes to PLAY. ack in PLAY is ignored.
- Reset values: count 0, winner 0, loser 0, winner_score 0, loser_score 0, gameover 0, who 00, FSM in PLAY.
- Reset asserted mid-game clears everything immediately, independent of the clock.

## Timing
- Registered outputs: the edge that samples the inputs updates count, winner/loser and the scores together. Latency is 1 cycle.
- gameover and who assert on the same edge as the final score increment.
- ack is sampled at an edge. The next cycle shows gameover=0 and count=0. A step applied in that same cycle takes effect at the following edge.
- Holding ack high across several cycles is harmless: after the first acknowledged edge the FSM is in PLAY, where ack is ignored.
- Release of rst_n is used synchronously by the FSM; an external reset synchroniser is assumed.

## Configuration
- MMC_SAT_EN defined: the counter saturates instead of wrapping.
  - Up: count_nxt = min(count+step, max).
  - Down: count_nxt = max(count−step, 0).
  - Reaching a rail scores once. Further steps into the same rail give count_nxt = count and do not score.
- MMC_SAT_EN undefined: modular wrap as described under Operation.

## Structure
- Package mmc_pkg holds:
  - who_t enum: WHO_NONE=2'b00, WHO_LOSER=2'b01, WHO_WINNER=2'b10.
  - state_t enum: PLAY, OVER.
  - Direction constants: DIR_UP=1'b0, DIR_DN=1'b1.
- Sub-module mmc_step_counter (parameters CNT_W, STEP_W):
  - Contains the count register, init load, wrap/saturate arithmetic and the MMC_SAT_EN selection.
  - Outputs count, hit_max and hit_min, each qualified by count_nxt ≠ count.
- Top level contains the FSM, score registers, pulse generation and the ack handshake.

## Test plan
All scenarios use the default parameters unless stated otherwise.
- Wrap up: init_val=5, then dir=0, step=2 → count goes 7 (winner pulse, winner_score=1), then 1, then 3. No loser pulse.
- Hold no-rescore: init_val=6, then dir=0, step=1 for one cycle → count=7, winner_score=1. Then step=0 for 10 cycles → winner_score stays 1 and winner stays 0.
- Game end and ack (WIN_SCORE=3): dir=1, step=1 from count 1 → loser_score reaches 3 on the third entry to 0; gameover=1 and who=01 on that edge. Step is then ignored for 5 cycles. ack=1 for one cycle → next cycle shows count=0, scores 0, who=00.
- Init priority: init=1, init_val=0, step=3 in the same cycle → count=0, no loser pulse, loser_score unchanged.
- Async reset mid-game: with winner_score=4, assert rst_n=0 between clock edges → all outputs 0 immediately, before the next edge.
- MMC_SAT_EN defined: count=6, dir=0, step=3 → count=7, winner_score=1. Step again → count stays 7, score stays 1.
